keypad_entry: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment display path: scans a 4x4 hex keypad column by column, debounces presses, and shifts each accepted hex digit into a 16-bit entry register.
- The entry register feeds the display/result path, so the value typed on the keypad can be shown on the four digits.
- Sits beside the display top, clocked by the same system clock.

---
 rtl/keypad_entry.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_entry.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : keypad_entry                                                  |
// | Purpose  : 4x4 hex keypad scanner with debounce, feeding a 16-bit        |
// |            shift-in entry register for the 7-segment display path.       |
// | Options  : KEY_AUTOREPEAT_EN - repeat a held key after 64 samples, then  |
// |            every 16 samples until release.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module keypad_entry #(
  parameter int SCAN_DELAY   = 1024,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clear,
  output logic [3:0]  col,
  output logic        keyValid,
  output logic [3:0]  keyCode,
  output logic [15:0] value,
  output logic [2:0]  digitCount,
  output logic        full
);

  localparam int DW = (SCAN_DELAY > 1) ? $clog2(SCAN_DELAY) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] dwell;
  logic          sample;
  logic          all_high;
  logic [1:0]    low_idx;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [1:0]    col_idx;
  logic [1:0]    col_idx_next;
  logic [1:0]    row_idx;
  logic [1:0]    row_idx_next;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] deb_next;
  logic [CW-1:0] rel_cnt;
  logic [CW-1:0] rel_next;
  logic          fire;

`ifdef KEY_AUTOREPEAT_EN
  logic [6:0]    rep_cnt;
  logic [6:0]    rep_next;
`endif

  assign sample   = (dwell == DW'(SCAN_DELAY - 1));
  assign all_high = &row_sync;
  assign col      = ~(4'b0001 << col_idx);
  assign full     = (digitCount == 3'd4);

  // Two-flop synchronizer for the asynchronous keypad rows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Lowest-index low row wins when several rows read low
  always_comb begin
    low_idx = 2'd0;
    if (!row_sync[0])      low_idx = 2'd0;
    else if (!row_sync[1]) low_idx = 2'd1;
    else if (!row_sync[2]) low_idx = 2'd2;
    else if (!row_sync[3]) low_idx = 2'd3;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_SCAN;
    else      state <= state_next;
  end

  // FSM next-state: transitions only happen on sample cycles
  always_comb begin
    state_next = state;
    if (sample) begin
      case (state)
        S_SCAN:
          if (!all_high) state_next = S_DEBOUNCE;
        S_DEBOUNCE:
          if (all_high || (low_idx != row_idx))            state_next = S_SCAN;
          else if (deb_cnt + CW'(1) == CW'(DEBOUNCE_CNT))  state_next = S_HELD;
        S_HELD:
          if (all_high && (rel_cnt + CW'(1) == CW'(DEBOUNCE_CNT))) state_next = S_SCAN;
        default:
          state_next = S_SCAN;
      endcase
    end
  end

  // FSM outputs: column rotation, debounce/release counters and accept strobe
  always_comb begin
    col_idx_next = col_idx;
    row_idx_next = row_idx;
    deb_next     = deb_cnt;
    rel_next     = rel_cnt;
    fire         = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rep_next     = rep_cnt;
`endif
    if (sample) begin
      case (state)
        S_SCAN: begin
          if (all_high) begin
            col_idx_next = col_idx + 2'd1;
          end else begin
            row_idx_next = low_idx;
            deb_next     = CW'(1);
          end
        end
        S_DEBOUNCE: begin
          if (all_high || (low_idx != row_idx)) begin
            col_idx_next = col_idx + 2'd1;
            deb_next     = '0;
          end else if (deb_cnt + CW'(1) == CW'(DEBOUNCE_CNT)) begin
            fire     = 1'b1;
            deb_next = '0;
            rel_next = '0;
`ifdef KEY_AUTOREPEAT_EN
            rep_next = 7'd0;
`endif
          end else begin
            deb_next = deb_cnt + CW'(1);
          end
        end
        S_HELD: begin
          if (all_high) begin
            if (rel_cnt + CW'(1) == CW'(DEBOUNCE_CNT)) begin
              rel_next     = '0;
              col_idx_next = col_idx + 2'd1;
            end else begin
              rel_next = rel_cnt + CW'(1);
            end
          end else begin
            rel_next = '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          // First repeat after 64 held samples, then every 16 (reload to 48)
          if (!all_high && (low_idx == row_idx)) begin
            if (rep_cnt + 7'd1 == 7'd64) begin
              fire     = 1'b1;
              rep_next = 7'd48;
            end else begin
              rep_next = rep_cnt + 7'd1;
            end
          end else begin
            rep_next = 7'd0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Scan datapath registers and the key report outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell    <= '0;
      col_idx  <= 2'd0;
      row_idx  <= 2'd0;
      deb_cnt  <= '0;
      rel_cnt  <= '0;
      keyValid <= 1'b0;
      keyCode  <= 4'h0;
    end else begin
      dwell    <= sample ? '0 : dwell + DW'(1);
      col_idx  <= col_idx_next;
      row_idx  <= row_idx_next;
      deb_cnt  <= deb_next;
      rel_cnt  <= rel_next;
      keyValid <= fire;
      if (fire) keyCode <= {row_idx, col_idx};
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  // Auto-repeat sample counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_cnt <= 7'd0;
    else      rep_cnt <= rep_next;
  end
`endif

  // Entry register: clear has priority over a same-cycle key
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value      <= 16'h0000;
      digitCount <= 3'd0;
    end else if (clear) begin
      value      <= 16'h0000;
      digitCount <= 3'd0;
    end else if (keyValid) begin
      value <= {value[11:0], keyCode};
      if (digitCount != 3'd4) digitCount <= digitCount + 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_keypad_entry                                               |
// | Purpose  : Directed self-checking bench for keypad_entry with a keypad   |
// |            model and a queue of expected key codes.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic        clear = 1'b0;
  logic [3:0]  col;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic [15:0] value;
  logic [2:0]  digitCount;
  logic        full;

  // keypad model controls
  logic       press_en   = 1'b0;
  logic [1:0] press_row  = 2'd0;
  logic [1:0] press_col  = 2'd0;
  logic       bounce_en  = 1'b0;
  logic       bounce_bit = 1'b1;

  int checks = 0;
  int errors = 0;
  int kv_count = 0;
  logic prev_kv = 1'b0;
  logic [3:0] exp_q[$];

  keypad_entry #(.SCAN_DELAY(4), .DEBOUNCE_CNT(4)) dut (
    .clk(clk), .rst(rst), .row(row), .clear(clear), .col(col),
    .keyValid(keyValid), .keyCode(keyCode), .value(value),
    .digitCount(digitCount), .full(full)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven
  assign row = bounce_en ? ((col == 4'hE) ? {3'b111, bounce_bit} : 4'hF)
             : (press_en && (col[press_col] == 1'b0)) ? ~(4'b0001 << press_row) : 4'hF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every keyValid pulse must match the oldest expected key
  always @(negedge clk) begin
    if (rst && keyValid) begin
      kv_count++;
      check("kv_single_cycle", {31'd0, prev_kv}, 32'd0);
      check("kv_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("keyCode", {28'd0, keyCode}, {28'd0, exp_q.pop_front()});
    end
    prev_kv = keyValid;
  end

  task automatic press_wait(input logic [1:0] r, input logic [1:0] c, input bit with_clear);
    int n;
    exp_q.push_back({r, c});
    press_row = r; press_col = c; press_en = 1'b1;
    n = 0;
    while (!keyValid && n < 400) begin @(negedge clk); n++; end
    if (!keyValid) check("kv_timeout", {31'd0, keyValid}, 32'd1);
    if (with_clear) clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic release_wait();
    int n;
    logic [3:0] c0;
    press_en = 1'b0;
    c0 = col;
    n = 0;
    while (col == c0 && n < 100) begin @(negedge clk); n++; end
    check("scan_resumed", {31'd0, col != c0}, 32'd1);
  endtask

  task automatic key(input logic [1:0] r, input logic [1:0] c);
    press_wait(r, c, 1'b0);
    repeat (8) @(negedge clk);
    release_wait();
  endtask

  initial begin
    logic [3:0] exp_col;
    int n;
    int rot;
    logic [3:0] pc;

    // ---- Test 1: reset and idle scanning ----
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", {28'd0, col}, 32'hE);
    check("rst_keyValid", {31'd0, keyValid}, 32'd0);
    check("rst_keyCode", {28'd0, keyCode}, 32'd0);
    check("rst_value", {16'd0, value}, 32'd0);
    check("rst_digitCount", {29'd0, digitCount}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    rst = 1'b1;
    n = 0;
    while (col == 4'hE && n < 8) begin @(negedge clk); n++; end
    check("idle_first_rotate", {28'd0, col}, 32'hD);
    exp_col = 4'hD;
    for (int i = 0; i < 14; i++) begin
      repeat (4) @(negedge clk);
      exp_col = {exp_col[2:0], exp_col[3]};
      check("idle_col", {28'd0, col}, {28'd0, exp_col});
    end
    check("idle_value", {16'd0, value}, 32'd0);
    check("idle_no_kv", kv_count, 32'd0);

    // ---- Test 2: row1 col1 held, single pulse, delayed resume ----
    press_wait(2'd1, 2'd1, 1'b0);
    repeat (30) @(negedge clk);
    check("k5_value", {16'd0, value}, 32'h0005);
    check("k5_digitCount", {29'd0, digitCount}, 32'd1);
    check("k5_keyCode", {28'd0, keyCode}, 32'h5);
    check("k5_one_pulse", kv_count, 32'd1);
    press_en = 1'b0;
    repeat (12) @(negedge clk);
    check("k5_col_held", {28'd0, col}, 32'hD);
    n = 0;
    while (col == 4'hD && n < 20) begin @(negedge clk); n++; end
    check("k5_col_resume", {28'd0, col}, 32'hB);

    // ---- Test 3: bouncing row0 on column 0 ----
    bounce_en = 1'b1;
    rot = 0;
    pc = col;
    for (int i = 0; i < 24; i++) begin
      repeat (4) begin
        @(negedge clk);
        if (col != pc) rot++;
        pc = col;
      end
      bounce_bit = ~bounce_bit;
    end
    bounce_en = 1'b0;
    check("bounce_scanning", {31'd0, rot >= 10}, 32'd1);
    check("bounce_no_kv", kv_count, 32'd1);
    check("bounce_value", {16'd0, value}, 32'h0005);

    // ---- Test 4: keys 1..5, saturation ----
    clear = 1'b1; @(negedge clk); clear = 1'b0; @(negedge clk);
    check("clr_value", {16'd0, value}, 32'd0);
    check("clr_digitCount", {29'd0, digitCount}, 32'd0);
    key(2'd0, 2'd1);
    check("k1_value", {16'd0, value}, 32'h0001);
    key(2'd0, 2'd2);
    key(2'd0, 2'd3);
    check("k3_full", {31'd0, full}, 32'd0);
    key(2'd1, 2'd0);
    check("k4_value", {16'd0, value}, 32'h1234);
    check("k4_full", {31'd0, full}, 32'd1);
    check("k4_digitCount", {29'd0, digitCount}, 32'd4);
    key(2'd1, 2'd1);
    check("k5b_value", {16'd0, value}, 32'h2345);
    check("k5b_digitCount", {29'd0, digitCount}, 32'd4);

    // ---- Test 5: clear coincident with keyValid ----
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    key(2'd0, 2'd1);
    key(2'd0, 2'd2);
    check("pre7_value", {16'd0, value}, 32'h0012);
    press_wait(2'd1, 2'd3, 1'b1);
    check("c7_value", {16'd0, value}, 32'd0);
    check("c7_digitCount", {29'd0, digitCount}, 32'd0);
    check("c7_keyCode", {28'd0, keyCode}, 32'h7);
    repeat (4) @(negedge clk);
    release_wait();
    key(2'd2, 2'd2);
    check("kA_value", {16'd0, value}, 32'h000A);

    // ---- Test 6: reset during debounce ----
    rst = 1'b0;
    repeat (2) @(negedge clk);
    press_row = 2'd0; press_col = 2'd0; press_en = 1'b1;
    rst = 1'b1;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_col", {28'd0, col}, 32'hE);
    check("arst_keyValid", {31'd0, keyValid}, 32'd0);
    check("arst_keyCode", {28'd0, keyCode}, 32'd0);
    check("arst_value", {16'd0, value}, 32'd0);
    check("arst_digitCount", {29'd0, digitCount}, 32'd0);
    check("arst_full", {31'd0, full}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (14) @(negedge clk);
    check("arst_no_early_kv", {31'd0, keyValid}, 32'd0);
    press_wait(2'd0, 2'd0, 1'b0);
    check("arst_redebounce_dc", {29'd0, digitCount}, 32'd1);
    repeat (4) @(negedge clk);
    release_wait();

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
